// File: rtl/kalman_pkg.sv
// Shared definitions for the Kalman predictor blocks.
//   DEF_DBL_WIDTH : default width of one IEEE-754 double element
//   DEF_N_CH      : default number of parallel CMU_PHi channel units
//   pphi_state_e  : state type of the pphi_collect controller
package kalman_pkg;

  localparam int DEF_DBL_WIDTH = 64;
  localparam int DEF_N_CH      = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } pphi_state_e;

endpackage

// File: rtl/pphi_slot_bank.sv
// Register bank holding one element per channel.
//   clk, rst   : clock, asynchronous active-high reset (slots reset to 0)
//   wr_mask_i  : per-slot write enable; slot i loads wr_data_i[i*W +: W]
//   wr_data_i  : packed write data, one W-bit field per slot
//   rd_idx_i   : read index
//   rd_data_o  : combinational read of slot rd_idx_i (0 if out of range)
module pphi_slot_bank #(
  parameter int W    = 64,
  parameter int N_CH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            wr_mask_i,
  input  logic [N_CH*W-1:0]          wr_data_i,
  input  logic [$clog2(N_CH)-1:0]    rd_idx_i,
  output logic [W-1:0]               rd_data_o
);

  localparam int IW = $clog2(N_CH);

  logic [W-1:0] slot_q [N_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_mask_i[i]) begin
          slot_q[i] <= wr_data_i[i*W +: W];
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_idx_i == IW'(i)) begin
        rd_data_o = slot_q[i];
      end
    end
  end

endmodule

// File: rtl/pphi_collect.sv
// Collects one predicted-covariance element from each of N_CH channel units
// for a prediction step, then streams them out in channel order.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : one-cycle pulse starting a step (ignored while busy)
//   ch_valid     : per-channel one-cycle valid pulse
//   ch_data      : channel i element at [i*DBL_WIDTH +: DBL_WIDTH]
//   out_valid    : element available on out_data/out_idx
//   out_ready    : downstream accepts
//   out_data     : element value
//   out_idx      : channel index of out_data
//   out_last     : high together with out_idx == N_CH-1
//   done         : one-cycle pulse after the last element is accepted
//   busy         : controller not in IDLE
//   err_dup      : sticky, a channel fired twice in one step
//   err_stray    : sticky, ch_valid seen outside COLLECT
//   err_timeout  : sticky, collection aborted after TIMEOUT_CYC cycles
//   dbg_state    : current controller state
//
// Output handshake: an element moves on every rising edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high, with out_data
// and out_idx unchanged, until that element has moved; out_valid never depends
// combinationally on out_ready.
module pphi_collect
  import kalman_pkg::*;
#(
  parameter int DBL_WIDTH   = DEF_DBL_WIDTH,
  parameter int N_CH        = DEF_N_CH,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_CH-1:0]             ch_valid,
  input  logic [N_CH*DBL_WIDTH-1:0]   ch_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DBL_WIDTH-1:0]        out_data,
  output logic [$clog2(N_CH)-1:0]     out_idx,
  output logic                        out_last,
  output logic                        done,
  output logic                        busy,
  output logic                        err_dup,
  output logic                        err_stray,
  output logic                        err_timeout,
  output pphi_state_e                 dbg_state
);

  localparam int IW = $clog2(N_CH);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_CH - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  pphi_state_e      state_q;
  logic [N_CH-1:0]  got_q;
  logic [N_CH-1:0]  got_d;
  logic [IW-1:0]    ptr_q;
  logic [CW-1:0]    tmo_q;
  logic             out_valid_q;
  logic             done_q;
  logic             err_dup_q;
  logic             err_stray_q;
  logic             err_timeout_q;

  logic [N_CH-1:0]      wr_mask;
  logic [DBL_WIDTH-1:0] rd_data;
  logic                 xfer;
  logic                 complete;

  // Mask including this cycle's arrivals; completion is judged on it so the
  // last channel moves straight to DRAIN at the same edge it is captured.
  assign got_d    = got_q | ch_valid;
  assign complete = &got_d;
  assign xfer     = out_valid_q & out_ready;

  // Only first arrivals are written, so a duplicate never overwrites.
  assign wr_mask  = (state_q == COLLECT) ? (ch_valid & ~got_q) : '0;

  pphi_slot_bank #(
    .W    (DBL_WIDTH),
    .N_CH (N_CH)
  ) u_slots (
    .clk       (clk),
    .rst       (rst),
    .wr_mask_i (wr_mask),
    .wr_data_i (ch_data),
    .rd_idx_i  (ptr_q),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      got_q         <= '0;
      ptr_q         <= '0;
      tmo_q         <= '0;
      out_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      err_dup_q     <= 1'b0;
      err_stray_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q       <= COLLECT;
            got_q         <= '0;
            tmo_q         <= '0;
            err_dup_q     <= 1'b0;
            err_stray_q   <= 1'b0;
            err_timeout_q <= 1'b0;
          end
          // Placed after the clear so a stray pulse coinciding with start
          // is still reported.
          if (|ch_valid) begin
            err_stray_q <= 1'b1;
          end
        end
        COLLECT: begin
          got_q <= got_d;
          if (|(ch_valid & got_q)) begin
            err_dup_q <= 1'b1;
          end
          // Completion takes priority over a timeout in the same cycle.
          if (complete) begin
            state_q     <= DRAIN;
            ptr_q       <= '0;
            out_valid_q <= 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            state_q       <= IDLE;
            err_timeout_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + CW'(1);
          end
        end
        DRAIN: begin
          if (|ch_valid) begin
            err_stray_q <= 1'b1;
          end
          if (xfer) begin
            if (ptr_q == IDX_LAST) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              ptr_q       <= '0;
            end else begin
              ptr_q <= ptr_q + IW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_valid_q ? rd_data : '0;
  assign out_idx     = ptr_q;
  assign out_last    = out_valid_q & (ptr_q == IDX_LAST);
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign err_dup     = err_dup_q;
  assign err_stray   = err_stray_q;
  assign err_timeout = err_timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pphi_collect.sv
// Self-checking bench for pphi_collect (N_CH=12, TIMEOUT_CYC=16).
module tb_pphi_collect;
  import kalman_pkg::*;

  localparam int DW  = 64;
  localparam int NC  = 12;
  localparam int TMO = 16;
  localparam int IW  = $clog2(NC);
  localparam int EW  = DW + IW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               start;
  logic [NC-1:0]      ch_valid;
  logic [NC*DW-1:0]   ch_data;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [IW-1:0]      out_idx;
  logic               out_last;
  logic               done;
  logic               busy;
  logic               err_dup;
  logic               err_stray;
  logic               err_timeout;
  pphi_state_e        dbg_state;

  pphi_collect #(.DBL_WIDTH(DW), .N_CH(NC), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .ch_valid(ch_valid), .ch_data(ch_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .done(done), .busy(busy),
    .err_dup(err_dup), .err_stray(err_stray), .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int beats_seen = 0;
  int ready_mode = 0;   // 0: always 1, 1: toggle, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference plan for one step: per-channel first-fire cycle and data
  int            fcyc [NC];
  logic [DW-1:0] fdata[NC];
  int            d_ch, d_cyc, win_end;
  logic [DW-1:0] d_data;
  bit            m_to, m_dup;

  typedef struct {
    int mode;     // 0 in order, 1 all at once, 2 reversed, 3 random, 4 last at cycle 15
    int rdy;
    int dup_ch;
    int miss_ch;
    bit poke;     // extra start pulse during DRAIN
    bit exp_dup;
    bit exp_to;
  } vec_t;

  task automatic plan_step(input int mode, input int dup_ch, input int miss_ch);
    int last;
    for (int i = 0; i < NC; i++) begin
      fdata[i] = {$urandom, $urandom};
      case (mode)
        0: begin fcyc[i] = i; fdata[i] = 64'h3FF0_0000_0000_0000 + 64'(i); end
        1: fcyc[i] = 0;
        2: fcyc[i] = NC - 1 - i;
        3: fcyc[i] = $urandom_range(0, TMO - 1);
        default: fcyc[i] = (i == NC - 1) ? TMO - 1 : 0;
      endcase
    end
    if (miss_ch >= 0) fcyc[miss_ch] = -1;
    m_to = 1'b0;
    last = 0;
    for (int i = 0; i < NC; i++) begin
      if (fcyc[i] < 0) m_to = 1'b1;
      else if (fcyc[i] > last) last = fcyc[i];
    end
    win_end = m_to ? TMO - 1 : last;
    d_ch = -1;
    d_cyc = -1;
    d_data = {$urandom, $urandom};
    if (dup_ch >= 0 && fcyc[dup_ch] >= 0 && fcyc[dup_ch] < win_end) begin
      d_ch  = dup_ch;
      d_cyc = $urandom_range(fcyc[dup_ch] + 1, win_end);
      if (mode == 0) begin
        fdata[dup_ch] = 64'h4000_0000_0000_0000;
        d_data        = 64'h4008_0000_0000_0000;
      end
    end
    m_dup = (d_ch >= 0);
  endtask

  task automatic drive_cyc(input int c);
    logic [NC-1:0]    v;
    logic [NC*DW-1:0] d;
    v = '0;
    for (int i = 0; i < NC; i++) begin
      d[i*DW +: DW] = {$urandom, $urandom};
      if (fcyc[i] == c) begin
        v[i] = 1'b1;
        d[i*DW +: DW] = fdata[i];
      end
    end
    if (d_ch >= 0 && d_cyc == c) begin
      v[d_ch] = 1'b1;
      d[d_ch*DW +: DW] = d_data;
    end
    ch_valid = v;
    ch_data  = d;
  endtask

  task automatic push_expected();
    logic [IW-1:0] ix;
    for (int i = 0; i < NC; i++) begin
      ix = IW'(i);
      exp_q.push_back({ix, fdata[i]});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic run_step(input int rdy, input bit poke, input bit e_dup, input bit e_to);
    bit seen;
    ready_mode = rdy;
    if (!e_to) push_expected();
    pulse_start();
    for (int c = 0; c <= win_end; c++) begin
      drive_cyc(c);
      @(negedge clk);
      chk("collect_busy", 64'(busy), 64'd1);
      chk("collect_no_valid", 64'(out_valid), 64'd0);
      if (c == 0) begin
        chk("start_clr_dup", 64'(err_dup), 64'd0);
        chk("start_clr_stray", 64'(err_stray), 64'd0);
        chk("start_clr_timeout", 64'(err_timeout), 64'd0);
      end
      @(posedge clk); #1;
    end
    ch_valid = '0;
    if (e_to) begin
      @(negedge clk);
      chk("timeout_busy", 64'(busy), 64'd0);
      chk("timeout_flag", 64'(err_timeout), 64'd1);
      chk("timeout_no_valid", 64'(out_valid), 64'd0);
      repeat (3) @(posedge clk);
      #1;
    end else begin
      @(negedge clk);
      chk("latency_valid", 64'(out_valid), 64'd1);
      chk("latency_idx", 64'(out_idx), 64'd0);
      if (poke) pulse_start();
      seen = 1'b0;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (done) begin seen = 1'b1; break; end
      end
      chk("done_seen", 64'(seen), 64'd1);
      chk("done_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
    end
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    chk("step_err_dup", 64'(err_dup), 64'(e_dup));
    chk("step_err_stray", 64'(err_stray), 64'd0);
    chk("step_err_timeout", 64'(err_timeout), 64'(e_to));
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_dup"}, 64'(err_dup), 64'd0);
    chk({tag, "_stray"}, 64'(err_stray), 64'd0);
    chk({tag, "_timeout"}, 64'(err_timeout), 64'd0);
    chk({tag, "_idx"}, 64'(out_idx), 64'd0);
    chk({tag, "_data"}, out_data, 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // out_ready driver
  initial begin
    bit tog;
    tog = 1'b1;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = tog; tog = ~tog; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // output monitor: beats, hold while stalled, done timing
  initial begin
    logic [EW-1:0] e;
    logic [DW-1:0] hold_data;
    logic [IW-1:0] hold_idx;
    bit pend_done, hold_pend;
    pend_done = 1'b0;
    hold_pend = 1'b0;
    hold_data = '0;
    hold_idx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_done = 1'b0;
        hold_pend = 1'b0;
        continue;
      end
      chk("done_timing", 64'(done), 64'(pend_done));
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", out_data, hold_data);
        chk("hold_idx", 64'(out_idx), 64'(hold_idx));
      end
      if (out_valid) begin
        chk("beat_last", 64'(out_last), 64'(out_idx == IW'(NC - 1)));
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_beat: idx %0d data %h, none expected", out_idx, out_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_idx", 64'(out_idx), 64'(e[EW-1:DW]));
            chk("beat_data", out_data, e[DW-1:0]);
            beats_seen++;
          end
        end
      end
      pend_done = out_valid && out_ready && out_last;
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_idx  = out_idx;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[7];

  initial begin
    int base;
    start    = 1'b0;
    ch_valid = '0;
    ch_data  = '0;
    tbl[0] = '{mode: 0, rdy: 0, dup_ch: -1, miss_ch: -1, poke: 0, exp_dup: 0, exp_to: 0};
    tbl[1] = '{mode: 1, rdy: 1, dup_ch: -1, miss_ch: -1, poke: 1, exp_dup: 0, exp_to: 0};
    tbl[2] = '{mode: 0, rdy: 0, dup_ch: 3,  miss_ch: -1, poke: 0, exp_dup: 1, exp_to: 0};
    tbl[3] = '{mode: 2, rdy: 2, dup_ch: -1, miss_ch: -1, poke: 0, exp_dup: 0, exp_to: 0};
    tbl[4] = '{mode: 4, rdy: 0, dup_ch: -1, miss_ch: -1, poke: 0, exp_dup: 0, exp_to: 0};
    tbl[5] = '{mode: 1, rdy: 0, dup_ch: -1, miss_ch: 7,  poke: 0, exp_dup: 0, exp_to: 1};
    tbl[6] = '{mode: 0, rdy: 0, dup_ch: -1, miss_ch: -1, poke: 0, exp_dup: 0, exp_to: 0};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // stray pulse in IDLE
    @(posedge clk); #1; ch_valid = 12'h020;
    @(posedge clk); #1; ch_valid = '0;
    @(negedge clk);
    chk("stray_flag", 64'(err_stray), 64'd1);
    chk("stray_idle", 64'(busy), 64'd0);

    for (int t = 0; t < 7; t++) begin
      plan_step(tbl[t].mode, tbl[t].dup_ch, tbl[t].miss_ch);
      run_step(tbl[t].rdy, tbl[t].poke, tbl[t].exp_dup, tbl[t].exp_to);
    end

    // reset after four beats of a drain
    ready_mode = 0;
    plan_step(1, -1, -1);
    push_expected();
    base = beats_seen;
    pulse_start();
    drive_cyc(0);
    @(posedge clk); #1; ch_valid = '0;
    for (int k = 0; k < 50; k++) begin
      if (beats_seen - base >= 4) break;
      @(posedge clk); #1;
    end
    chk("rst_after_beats", 64'(beats_seen - base), 64'd4);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b0;

    plan_step(0, -1, -1);
    run_step(0, 1'b0, 1'b0, 1'b0);

    // randomized steps
    for (int r = 0; r < 20; r++) begin
      int dc, mc;
      dc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NC - 1)) : -1;
      mc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NC - 1)) : -1;
      plan_step(3, dc, mc);
      run_step(int'($urandom_range(0, 2)), 1'b0, m_dup, m_to);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
